// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared state type and index-width helper for the write-port arbiter.
package axi_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// axi_rr_pick: combinational round-robin picker, first set req searching circularly from ptr.
// Ports: req (request vector), ptr (search start), any_req (some req set), winner (picked index).
module axi_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any_req,
    output logic [IW-1:0] winner
);

    localparam logic [IW:0] NW = (IW + 1)'(N);

    logic [2*N-1:0] dbl;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;
    logic [IW:0]    sub;

    // Rotating the doubled vector right by ptr puts requester ptr at bit 0.
    assign dbl     = {req, req} >> ptr;
    assign any_req = |req;

    always_comb begin
        off = '0;
        for (int j = N - 1; j >= 0; j--)
            if (dbl[j]) off = IW'(j);
        sum    = {1'b0, ptr} + {1'b0, off};
        sub    = sum - NW;
        winner = (sum >= NW) ? sub[IW-1:0] : sum[IW-1:0];
    end

endmodule

// File: rtl/axi_fifo_wr_arbiter.sv
// axi_fifo_wr_arbiter: burst-locked round-robin arbiter sharing one axi_fifo write port.
// Ports: clk, reset (sync active-high); req_valid/req_data/req_last/req_ready per requester;
//        fifo_push/fifo_wdata/fifo_wsrc/fifo_wlast to the FIFO, fifo_full from it;
//        grant_valid/grant_id report the held grant.
// Option: define AXI_ARB_BURST_LIMIT_EN to cap a grant at MAX_BURST beats and add burst_overrun.
module axi_fifo_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 32,
    parameter  int MAX_BURST = 16,
    localparam int IDX_W     = idx_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     fifo_push,
    output logic [WIDTH-1:0]         fifo_wdata,
    output logic [IDX_W-1:0]         fifo_wsrc,
    output logic                     fifo_wlast,
    input  logic                     fifo_full,
    output logic                     grant_valid,
    output logic [IDX_W-1:0]         grant_id
`ifdef AXI_ARB_BURST_LIMIT_EN
    ,
    output logic                     burst_overrun
`endif
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1) begin : g_bad_cfg
        $error("axi_fifo_wr_arbiter: unsupported parameter set");
    end

    arb_state_e               state, state_n;
    logic [IDX_W-1:0]         grant_n, ptr, ptr_n, winner, ptr_inc;
    logic                     any_req, burst, ready_en, rel, limit_hit;
    logic [NUM_REQ-1:0]       one_hot;
    logic [NUM_REQ*WIDTH-1:0] data_sh;

    axi_rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .any_req (any_req),
        .winner  (winner)
    );

    assign burst       = state == ARB_BURST;
    assign grant_valid = burst;
    // Reset gates the handshake combinationally so an abandoned burst never leaks a beat.
    assign ready_en    = burst && !fifo_full && !reset;
    assign one_hot     = {{(NUM_REQ - 1){1'b0}}, 1'b1} << grant_id;
    assign req_ready   = ready_en ? one_hot : '0;
    assign fifo_push   = ready_en && req_valid[grant_id];
    assign data_sh     = req_data >> (grant_id * WIDTH);
    assign fifo_wdata  = data_sh[WIDTH-1:0];
    assign fifo_wsrc   = grant_id;
    assign fifo_wlast  = req_last[grant_id] || limit_hit;
    assign rel         = fifo_push && fifo_wlast;
    assign ptr_inc     = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef AXI_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] cnt, cnt_n;

    // cnt counts beats already pushed, so cnt == MAX_BURST-1 marks the MAX_BURST-th beat.
    assign limit_hit     = burst && (cnt == CW'(MAX_BURST - 1));
    assign burst_overrun = fifo_push && limit_hit && !req_last[grant_id];
    assign cnt_n         = burst ? cnt + CW'(fifo_push) : '0;

    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else cnt <= cnt_n;
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_n = burst ? (rel ? ARB_IDLE : ARB_BURST) : (any_req ? ARB_BURST : ARB_IDLE);
        grant_n = (!burst && any_req) ? winner : grant_id;
        ptr_n   = rel ? ptr_inc : ptr;
    end

    always_ff @(posedge clk)
        if (reset) begin
            state    <= ARB_IDLE;
            grant_id <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            grant_id <= grant_n;
            ptr      <= ptr_n;
        end

endmodule

// File: tb/tb_axi_fifo_wr_arbiter.sv
// tb_axi_fifo_wr_arbiter: directed self-checking bench for the write-port arbiter.
module tb_axi_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   r4_valid, r4_last, r4_ready;
    logic [127:0] r4_data;
    logic         p4, wl4, gv4, full4;
    logic [31:0]  wd4;
    logic [1:0]   ws4, gi4;
    logic [2:0]   r3_valid, r3_last, r3_ready;
    logic [95:0]  r3_data;
    logic         p3, wl3, gv3, full3;
    logic [31:0]  wd3;
    logic [1:0]   ws3, gi3;
`ifdef AXI_ARB_BURST_LIMIT_EN
    logic         ovr4, ovr3;
`endif
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    axi_fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(32), .MAX_BURST(4)) u4 (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (r4_valid),
        .req_data    (r4_data),
        .req_last    (r4_last),
        .req_ready   (r4_ready),
        .fifo_push   (p4),
        .fifo_wdata  (wd4),
        .fifo_wsrc   (ws4),
        .fifo_wlast  (wl4),
        .fifo_full   (full4),
        .grant_valid (gv4),
        .grant_id    (gi4)
`ifdef AXI_ARB_BURST_LIMIT_EN
        ,
        .burst_overrun (ovr4)
`endif
    );

    axi_fifo_wr_arbiter #(.NUM_REQ(3), .WIDTH(32), .MAX_BURST(16)) u3 (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (r3_valid),
        .req_data    (r3_data),
        .req_last    (r3_last),
        .req_ready   (r3_ready),
        .fifo_push   (p3),
        .fifo_wdata  (wd3),
        .fifo_wsrc   (ws3),
        .fifo_wlast  (wl3),
        .fifo_full   (full3),
        .grant_valid (gv3),
        .grant_id    (gi3)
`ifdef AXI_ARB_BURST_LIMIT_EN
        ,
        .burst_overrun (ovr3)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        full4 = 1'b0;
        full3 = 1'b0;
        r4_valid = '0; r4_last = '0; r4_data = '0;
        r3_valid = '0; r3_last = '0; r3_data = '0;
        cyc; cyc;
        #1;
        chk("rst_push", p4, 0);
        chk("rst_ready", r4_ready, 0);
        chk("rst_gv", gv4, 0);
        chk("rst_gid", gi4, 0);
        cyc;
        reset = 1'b0;
        // single requester 2, three beats
        r4_valid = 4'b0100; r4_data[64+:32] = 32'hA0;
        #1;
        chk("t1_idle_push", p4, 0);
        chk("t1_idle_ready", r4_ready, 0);
        cyc; #1;
        chk("t1_gv", gv4, 1);
        chk("t1_gid", gi4, 2);
        chk("t1_push0", p4, 1);
        chk("t1_src0", ws4, 2);
        chk("t1_data0", wd4, 32'hA0);
        chk("t1_last0", wl4, 0);
        chk("t1_ready0", r4_ready, 4'b0100);
        cyc; r4_data[64+:32] = 32'hA1; #1;
        chk("t1_push1", p4, 1);
        chk("t1_data1", wd4, 32'hA1);
        chk("t1_last1", wl4, 0);
        cyc; r4_data[64+:32] = 32'hA2; r4_last = 4'b0100; #1;
        chk("t1_push2", p4, 1);
        chk("t1_data2", wd4, 32'hA2);
        chk("t1_last2", wl4, 1);
        cyc; r4_valid = '0; r4_last = '0; #1;
        chk("t1_idle_after", gv4, 0);
        chk("t1_nopush_after", p4, 0);
        cyc; reset = 1'b1;
        cyc; reset = 1'b0;
        // round robin, all requesters with single-beat bursts
        r4_valid = 4'b1111; r4_last = 4'b1111;
        r4_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        #1;
        chk("t2_idle", gv4, 0);
        for (int i = 0; i < 5; i++) begin
            cyc; #1;
            chk("t2_push", p4, 1);
            chk("t2_src", ws4, i % 4);
            chk("t2_data", wd4, 32'hB0 + (i % 4));
            chk("t2_wlast", wl4, 1);
            cyc; #1;
            chk("t2_bubble", p4, 0);
        end
        r4_valid = '0; r4_last = '0;
        cyc; reset = 1'b1;
        cyc; reset = 1'b0;
        // backpressure mid-burst of requester 1
        r4_valid = 4'b0010; r4_data[32+:32] = 32'hC0;
        #1;
        chk("t3_idle", gv4, 0);
        cyc; #1;
        chk("t3_push0", p4, 1);
        chk("t3_src0", ws4, 1);
        chk("t3_data0", wd4, 32'hC0);
        cyc; r4_data[32+:32] = 32'hC1; full4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_full_push", p4, 0);
            chk("t3_full_ready", r4_ready, 0);
            chk("t3_full_gv", gv4, 1);
            cyc;
        end
        full4 = 1'b0; #1;
        chk("t3_push1", p4, 1);
        chk("t3_data1", wd4, 32'hC1);
        cyc; r4_data[32+:32] = 32'hC2; #1;
        chk("t3_push2", p4, 1);
        chk("t3_data2", wd4, 32'hC2);
        cyc; r4_data[32+:32] = 32'hC3; r4_last = 4'b0010; #1;
        chk("t3_push3", p4, 1);
        chk("t3_data3", wd4, 32'hC3);
        chk("t3_last3", wl4, 1);
        cyc; r4_valid = '0; r4_last = '0; #1;
        chk("t3_idle_after", gv4, 0);
        // reset mid-burst of requester 3 (pointer is 2 here)
        cyc; r4_valid = 4'b1000; r4_data[96+:32] = 32'hD0; #1;
        chk("t4_idle", gv4, 0);
        cyc; #1;
        chk("t4_gid", gi4, 3);
        chk("t4_data0", wd4, 32'hD0);
        cyc; r4_data[96+:32] = 32'hD1; #1;
        chk("t4_data1", wd4, 32'hD1);
        cyc; r4_data[96+:32] = 32'hD2; reset = 1'b1; #1;
        chk("t4_rst_push", p4, 0);
        chk("t4_rst_ready", r4_ready, 0);
        cyc; reset = 1'b0;
        r4_valid = 4'b1001; r4_last = 4'b0001;
        r4_data[0+:32] = 32'hE0; r4_data[96+:32] = 32'hD0;
        #1;
        chk("t4_gv_after_rst", gv4, 0);
        cyc; #1;
        chk("t4_ptr0_gid", gi4, 0);
        chk("t4_ptr0_push", p4, 1);
        chk("t4_ptr0_data", wd4, 32'hE0);
        cyc; r4_valid = 4'b1000; r4_last = '0; #1;
        chk("t4_bubble", gv4, 0);
        cyc; #1;
        chk("t4_regrant", gi4, 3);
        chk("t4_restart_data", wd4, 32'hD0);
        r4_valid = '0;
        cyc; reset = 1'b1;
        cyc; reset = 1'b0;
        // NUM_REQ=3 pointer wrap
        r3_valid = 3'b100; r3_last = 3'b100; r3_data[64+:32] = 32'h55;
        #1;
        chk("t5_idle", gv3, 0);
        cyc; #1;
        chk("t5_gid2", gi3, 2);
        chk("t5_push2", p3, 1);
        chk("t5_src2", ws3, 2);
        cyc; r3_valid = 3'b101; r3_last = 3'b101; r3_data[0+:32] = 32'h66; #1;
        chk("t5_bubble", gv3, 0);
        cyc; #1;
        chk("t5_wrap_gid", gi3, 0);
        chk("t5_wrap_src", ws3, 0);
        chk("t5_wrap_data", wd3, 32'h66);
        r3_valid = '0; r3_last = '0;
`ifdef AXI_ARB_BURST_LIMIT_EN
        // burst cap of 4 beats on requester 0
        cyc; r4_valid = 4'b0001; r4_last = '0; r4_data[0+:32] = 32'hF0; #1;
        chk("t6_idle", gv4, 0);
        chk("t6_ovr_idle", ovr4, 0);
        for (int i = 0; i < 4; i++) begin
            cyc; r4_data[0+:32] = 32'hF0 + i; #1;
            chk("t6_push", p4, 1);
            chk("t6_data", wd4, 32'hF0 + i);
            chk("t6_wlast", wl4, i == 3);
            chk("t6_ovr", ovr4, i == 3);
        end
        cyc; r4_data[0+:32] = 32'hF4; #1;
        chk("t6_release", gv4, 0);
        chk("t6_ovr_off", ovr4, 0);
        cyc; #1;
        chk("t6_regrant", gi4, 0);
        chk("t6_data4", wd4, 32'hF4);
        chk("t6_wlast4", wl4, 0);
        cyc; r4_data[0+:32] = 32'hF5; r4_last = 4'b0001; #1;
        chk("t6_data5", wd4, 32'hF5);
        chk("t6_wlast5", wl4, 1);
        chk("t6_ovr5", ovr4, 0);
        cyc; r4_valid = '0; r4_last = '0; #1;
        chk("t6_idle_after", gv4, 0);
`endif
        cyc;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
